// File: rtl/clb_cfg_ctrl.sv
// Serial configuration loader for a row of CLB slices: hunts for a sync word, shifts in a
// payload, checks even parity and commits the per-slice mode word.
module clb_cfg_ctrl #(
  parameter int unsigned NSLICE  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  input  logic                  cfg_bit_i,
  output logic                  cfg_ready_o,
  output logic [2*NSLICE-1:0]   mode_o,
  output logic                  busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic [7:0]            cfg_cnt_o
);

  localparam int unsigned W = 2 * NSLICE;

  typedef enum logic [1:0] {StHunt, StLoad, StParity, StCommit} state_e;

  state_e       state_q, state_d;
  logic [3:0]   win_q, win_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] mode_q, mode_d;
  logic [4:0]   bits_q, bits_d;
  logic [7:0]   idle_q, idle_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         ok_q, ok_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         xfer;

  assign xfer = cfg_valid_i & ready_q;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    bits_d   = bits_q;
    idle_d   = idle_q;
    cnt_d    = cnt_q;
    ok_d     = ok_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (xfer) begin
          win_d = {win_q[2:0], cfg_bit_i};
          if (win_d == 4'b1011) begin
            state_d = StLoad;
            bits_d  = '0;
            idle_d  = '0;
          end
        end
      end
      StLoad, StParity: begin
        if (xfer) begin
          idle_d = '0;
          if (state_q == StLoad) begin
            shadow_d = {shadow_q[W-2:0], cfg_bit_i};
            bits_d   = bits_q + 5'd1;
            if (bits_q == 5'(W - 1)) state_d = StParity;
          end else begin
            // Even parity: payload plus parity bit must XOR to zero.
            ok_d    = ~(^shadow_q ^ cfg_bit_i);
            state_d = StCommit;
          end
        end else if (idle_q == 8'(TIMEOUT - 1)) begin
          state_d  = StHunt;
          err_d    = 1'b1;
          shadow_d = '0;
          win_d    = '0;
          idle_d   = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      StCommit: begin
        if (ok_q) begin
          mode_d = shadow_q;
          done_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
        state_d = StHunt;
        win_d   = '0;
      end
    endcase

    ready_d = (state_d != StCommit);
    busy_d  = (state_d != StHunt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StHunt;
      win_q    <= '0;
      shadow_q <= '0;
      mode_q   <= '1;
      bits_q   <= '0;
      idle_q   <= '0;
      cnt_q    <= '0;
      ok_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      bits_q   <= bits_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      ok_q     <= ok_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign mode_o      = mode_q;
  assign busy_o      = busy_q;
  assign cfg_done_o  = done_q;
  assign cfg_err_o   = err_q;
  assign cfg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_clb_cfg_ctrl.sv
// Bench for clb_cfg_ctrl: vector table, hand-written corner sequences and a random stream
// checked against a queue-based frame parser.
module tb_clb_cfg_ctrl;

  localparam int unsigned NSLICE  = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned W       = 2 * NSLICE;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         bit_in;
  logic         ready;
  logic [W-1:0] mode;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   cnt;

  always #5 clk = ~clk;

  clb_cfg_ctrl #(
    .NSLICE (NSLICE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(valid),
    .cfg_bit_i  (bit_in),
    .cfg_ready_o(ready),
    .mode_o     (mode),
    .busy_o     (busy),
    .cfg_done_o (done),
    .cfg_err_o  (err),
    .cfg_cnt_o  (cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int guard = 0;
    valid  = 1'b1;
    bit_in = b;
    while (!ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!ready) check("ready_wait", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pre, input int pre_len, input logic [W-1:0] pay,
                            input logic par);
    for (int i = pre_len - 1; i >= 0; i--) send_bit(pre[i]);
    for (int i = W - 1; i >= 0; i--) send_bit(pay[i]);
    send_bit(par);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Called just after the parity-bit transfer edge.
  task automatic check_commit(input string name, input logic exp_done, input logic exp_err,
                              input logic [W-1:0] exp_mode, input logic [7:0] exp_cnt);
    check({name, "_commit_ready"}, 32'(ready), 32'd0);
    check({name, "_commit_busy"}, 32'(busy), 32'd1);
    tick();
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_mode"}, 32'(mode), 32'(exp_mode));
    check({name, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_ready_after"}, 32'(ready), 32'd1);
    tick();
    check({name, "_pulse_end"}, 32'({done, err}), 32'd0);
  endtask

  // Reference model: frame parser over the stream of accepted bits.
  logic         m_in;
  logic         m_win[$];
  logic         m_frame[$];
  logic [W-1:0] m_mode;
  int           m_cnt;

  task automatic model_reset();
    m_in    = 1'b0;
    m_win   = {};
    m_frame = {};
    m_mode  = '1;
    m_cnt   = 0;
  endtask

  // Returns 0: frame in progress / hunting, 1: good commit, 2: parity error.
  task automatic model_push(input logic b, output int res);
    int           ones;
    logic [W-1:0] pay;
    res = 0;
    if (!m_in) begin
      m_win.push_back(b);
      if (m_win.size() > 4) void'(m_win.pop_front());
      if (m_win.size() == 4 && m_win[0] && !m_win[1] && m_win[2] && m_win[3]) begin
        m_in    = 1'b1;
        m_frame = {};
      end
      return;
    end
    m_frame.push_back(b);
    if (m_frame.size() < W + 1) return;
    ones = 0;
    pay  = '0;
    for (int i = 0; i <= W; i++) ones += int'(m_frame[i]);
    for (int i = 0; i < W; i++) pay[W-1-i] = m_frame[i];
    m_in  = 1'b0;
    m_win = {};
    if (ones % 2 == 0) begin
      m_mode = pay;
      if (m_cnt < 255) m_cnt++;
      res = 1;
    end else begin
      res = 2;
    end
  endtask

  typedef struct {
    logic [7:0]   pre;
    int           pre_len;
    logic [W-1:0] pay;
    logic         par;
    logic         exp_done;
    logic         exp_err;
    logic [W-1:0] exp_mode;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pulses;
    int res;
    logic bits[$];
    logic [W-1:0] pay;

    vecs[0] = '{8'b1011,     4, 8'h1B, 1'b0, 1'b1, 1'b0, 8'h1B, 8'd1};
    vecs[1] = '{8'b1011,     4, 8'h1B, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd0};
    vecs[2] = '{8'b11011,    5, 8'hE4, 1'b0, 1'b1, 1'b0, 8'hE4, 8'd1};
    vecs[3] = '{8'b1011,     4, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'd1};
    vecs[4] = '{8'b1011,     4, 8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 8'd1};
    vecs[5] = '{8'b1011,     4, 8'h07, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd0};
    vecs[6] = '{8'b00101011, 8, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 8'd1};

    rst    = 1'b1;
    valid  = 1'b0;
    bit_in = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_mode", 32'(mode), 32'hFF);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, err}), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready_after", 32'(ready), 32'd1);
    // No timeout while hunting.
    repeat (TIMEOUT + 5) tick();
    check("hunt_no_timeout", 32'({err, busy}), 32'd0);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      send_frame(vecs[i].pre, vecs[i].pre_len, vecs[i].pay, vecs[i].par);
      check_commit($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err,
                   vecs[i].exp_mode, vecs[i].exp_cnt);
    end

    // Timeout mid-frame, then a good frame.
    do_reset();
    send_frame(8'b1011, 4, 8'h00, 1'b0);
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      tick();
      if (i < int'(TIMEOUT)) begin
        check($sformatf("to_idle%0d_err", i), 32'(err), 32'd0);
        check($sformatf("to_idle%0d_busy", i), 32'(busy), 32'd1);
      end
    end
    check("to_err", 32'(err), 32'd1);
    check("to_done", 32'(done), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    check("to_mode", 32'(mode), 32'h00);
    check("to_cnt", 32'(cnt), 32'd1);
    tick();
    check("to_err_end", 32'(err), 32'd0);
    send_frame(8'b1011, 4, 8'h1B, 1'b0);
    check_commit("to_next", 1'b1, 1'b0, 8'h1B, 8'd2);

    // Reset in the middle of the payload.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst    = 1'b1;
    valid  = 1'b1;
    bit_in = 1'b1;
    tick();
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_mode", 32'(mode), 32'hFF);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_flags", 32'({busy, done, err}), 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    tick();
    check("mid_rst_ready_after", 32'(ready), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    tick();
    check("mid_rst_abandoned", 32'({busy, done, err}), 32'd0);
    check("mid_rst_mode_kept", 32'(mode), 32'hFF);

    // Saturation.
    do_reset();
    pulses = 0;
    for (int f = 0; f < 256; f++) begin
      send_frame(8'b1011, 4, 8'h1B, 1'b0);
      tick();
      if (done) pulses++;
    end
    check("sat_pulses", 32'(pulses), 32'd256);
    check("sat_cnt", 32'(cnt), 32'd255);
    check("sat_mode", 32'(mode), 32'h1B);

    // Random stream against the reference parser.
    do_reset();
    model_reset();
    for (int f = 0; f < 40; f++) begin
      bits = {};
      repeat ($urandom_range(0, 5)) bits.push_back(1'($urandom_range(0, 1)));
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      bits.push_back(1'b1);
      bits.push_back(1'b1);
      pay = W'($urandom);
      for (int i = W - 1; i >= 0; i--) bits.push_back(pay[i]);
      bits.push_back((^pay) ^ ($urandom_range(0, 3) == 0));
      foreach (bits[k]) begin
        repeat ($urandom_range(0, 3)) tick();
        send_bit(bits[k]);
        model_push(bits[k], res);
        if (res == 0) begin
          check("rnd_no_pulse", 32'({done, err}), 32'd0);
          check("rnd_busy", 32'(busy), 32'(m_in));
        end else begin
          check("rnd_commit_ready", 32'(ready), 32'd0);
          tick();
          check("rnd_done", 32'(done), 32'(res == 1));
          check("rnd_err", 32'(err), 32'(res == 2));
          check("rnd_mode", 32'(mode), 32'(m_mode));
          check("rnd_cnt", 32'(cnt), 32'(m_cnt));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clb_cfg_ctrl.md
CLB_CFG_CTRL -- requirements
Module: clb_cfg_ctrl

Interface
REQ-001 SHALL have parameter NSLICE, default 4, number of CLB slices configured (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum idle cycles allowed mid-frame (1..255).
REQ-003 SHALL have port clk_i, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid_i, input, 1, serial config bit valid.
REQ-006 SHALL have port cfg_bit_i, input, 1, serial config data bit.
REQ-007 SHALL have port cfg_ready_o, output, 1, controller accepts a bit this cycle.
REQ-008 SHALL have port mode_o, output, 2*NSLICE, committed mode per slice; slice i uses bits [2i+1:2i]. Encoding: 00 AND, 01 OR, 10 XOR, 11 force-0.
REQ-009 SHALL have port busy_o, output, 1, high while in LOAD, PARITY or COMMIT.
REQ-010 SHALL have port cfg_done_o, output, 1, one-cycle pulse on successful commit.
REQ-011 SHALL have port cfg_err_o, output, 1, one-cycle pulse on parity failure or timeout.
REQ-012 SHALL have port cfg_cnt_o, output, 8, count of successful commits, saturating at 255.

Function
REQ-013 SHALL transfer a bit only on a rising edge where cfg_valid_i and cfg_ready_o are both 1.
REQ-014 SHALL implement the states HUNT, LOAD, PARITY and COMMIT, all outputs registered.
REQ-015 SHALL define a frame as sync 1,0,1,1, then 2*NSLICE payload bits with slice NSLICE-1 MSB first, then 1 even-parity bit over the payload.
REQ-016 HUNT: SHALL shift each transferred bit into a 4-bit window, cleared on HUNT entry, and go to LOAD on the transfer that makes the window equal 1011; mismatches stay in HUNT (sliding match).
REQ-017 LOAD: SHALL shift each transferred bit into a shadow register and go to PARITY after exactly 2*NSLICE transfers.
REQ-018 PARITY: SHALL go to COMMIT on the next transfer, recording parity_ok = (XOR of payload and parity bit) == 0.
REQ-019 COMMIT: SHALL last exactly 1 cycle with cfg_ready_o=0, then go to HUNT.
REQ-020 COMMIT: if parity_ok, SHALL set mode_o to the shadow value, pulse cfg_done_o and increment cfg_cnt_o; otherwise SHALL leave mode_o unchanged and pulse cfg_err_o.
REQ-021 mode_o and the pulse SHALL become visible after the edge ending COMMIT, i.e. 2 edges after the parity-bit transfer edge.
REQ-022 cfg_ready_o SHALL be 1 in HUNT, LOAD and PARITY.
REQ-023 Timeout: in LOAD or PARITY, SHALL count consecutive cycles without a transfer, clearing the count on each transfer.
REQ-024 When the timeout count reaches TIMEOUT, SHALL discard the shadow, pulse cfg_err_o, leave mode_o unchanged and go to HUNT.
REQ-025 The timeout count SHALL not run in HUNT.
REQ-026 cfg_cnt_o SHALL hold at 255; a commit at 255 still updates mode_o and pulses cfg_done_o.
REQ-027 cfg_done_o and cfg_err_o SHALL never be 1 in the same cycle.

Reset
REQ-028 When rst_i=1 at an edge, in any state and dominating a simultaneous transfer or commit, SHALL set state=HUNT, window=0, shadow=0, timeout count=0, mode_o=all 1s (every slice force-0), cfg_cnt_o=0 and cfg_done_o=cfg_err_o=busy_o=0.
REQ-029 cfg_ready_o SHALL be 0 in the reset cycle and 1 from the first cycle after reset deasserts.
REQ-030 A reset mid-frame SHALL abandon the frame without updating mode_o.

Verification
REQ-031 Good frame (NSLICE=4): bits 1011 00011011 0, back-to-back -> mode_o=8'h1B, cfg_done_o pulses once 2 edges after the last transfer, cfg_cnt_o=1, busy_o low afterward.
REQ-032 Bad parity: same payload with parity bit 1 -> cfg_err_o pulses once, mode_o stays 8'hFF, cfg_cnt_o=0.
REQ-033 Sliding sync: bits 1,1,0,1,1 then payload 8'hE4 and parity 0 -> mode_o=8'hE4 (match found at the 5th bit).
REQ-034 Timeout: send sync plus 3 payload bits, then hold cfg_valid_i=0 for 15 cycles -> cfg_err_o pulses on the 15th idle cycle, state returns to HUNT, and a following good frame commits normally.
REQ-035 Reset mid-LOAD: assert rst_i after 5 payload bits -> mode_o=8'hFF, cfg_cnt_o=0, no pulse, cfg_ready_o=0 during reset and 1 after.
REQ-036 Saturation: 256 good frames -> cfg_cnt_o=255 and cfg_done_o pulses on every frame.
